// File: rtl/q_transpose_pkg.sv
// Shared types and default widths for the matrix transpose streamer.
package q_transpose_pkg;

   localparam int DEF_WORDLEN        = 16;
   localparam int DEF_FRACTION_WIDTH = 12;

   typedef enum logic [1:0] {
      FILL   = 2'd0,
      FULL   = 2'd1,
      STREAM = 2'd2
   } state_t;

   typedef enum logic {
      TRANSPOSE = 1'b0,
      PASS      = 1'b1
   } mode_t;

endpackage

// File: rtl/q_transpose_stream_rc_counter.sv
// Row/column counter over an N x N grid; column is the fast index and
// both wrap at N-1. last flags the final cell (N-1, N-1).
module rc_counter #(
   parameter int N  = 3,
   parameter int CW = $clog2(N)
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          en,
   output logic [CW-1:0] row,
   output logic [CW-1:0] col,
   output logic          last
);

   localparam logic [CW-1:0] MAX_IDX = CW'(N - 1);

   always_ff @(posedge CLK) begin
      if (RST) begin
         row <= '0;
         col <= '0;
      end else if (en) begin
         if (col == MAX_IDX) begin
            col <= '0;
            row <= (row == MAX_IDX) ? '0 : row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   assign last = (row == MAX_IDX) && (col == MAX_IDX);

endmodule

// File: rtl/q_transpose_stream.sv
// Collects an N x N matrix in row-major order, LANES elements per beat, then
// streams it out one element per handshake, either transposed or as stored.
module q_transpose_stream
   import q_transpose_pkg::*;
#(
   parameter int WORDLEN        = DEF_WORDLEN,
   parameter int FRACTION_WIDTH = DEF_FRACTION_WIDTH,
   parameter int N              = 3,
   parameter int LANES          = 2
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [LANES*WORDLEN-1:0] in_data,
   input  logic                     start,
   input  logic                     mode,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WORDLEN-1:0]       out_data,
   output logic                     out_last,
   output logic                     full,
   output logic                     busy,
   output logic                     err_start
);

   localparam int DEPTH = N * N;
   localparam int IDX_W = $clog2(DEPTH);
   localparam int CW    = $clog2(N);

   generate
      if (N < 2 || N > 8 || LANES < 1 || LANES > 4 || FRACTION_WIDTH > WORDLEN) begin : g_param_check
         $error("q_transpose_stream: parameter out of range");
      end
   endgenerate

   state_t               state;
   mode_t                mode_q;
   logic [IDX_W-1:0]     wr_idx;
   logic [IDX_W:0]       wr_end;
   logic [IDX_W-1:0]     rd_idx;
   logic [CW-1:0]        row;
   logic [CW-1:0]        col;
   logic                 at_last;
   logic                 accept;
   logic                 take;
   logic [WORDLEN-1:0]   mem [DEPTH];

   assign accept = in_valid && in_ready;
   assign take   = out_valid && out_ready;
   assign wr_end = {1'b0, wr_idx} + (IDX_W+1)'(LANES);

   rc_counter #(.N(N), .CW(CW)) u_rc_counter (
      .CLK  (CLK),
      .RST  (RST),
      .en   (take),
      .row  (row),
      .col  (col),
      .last (at_last)
   );

   // NOTE: state and flags use non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= FILL;
         mode_q    <= TRANSPOSE;
         wr_idx    <= '0;
         err_start <= 1'b0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         full      <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            FILL: begin
               if (start) err_start <= 1'b1;
               // A beat that reaches the end of the matrix completes the fill;
               // lanes past the end are dropped by the write port.
               if (accept && wr_end >= (IDX_W+1)'(DEPTH)) begin
                  state    <= FULL;
                  in_ready <= 1'b0;
                  full     <= 1'b1;
               end else begin
                  if (accept) wr_idx <= wr_idx + IDX_W'(LANES);
                  in_ready <= 1'b1;
               end
            end
            FULL: begin
               if (start) begin
                  mode_q    <= mode_t'(mode);
                  state     <= STREAM;
                  full      <= 1'b0;
                  out_valid <= 1'b1;
                  busy      <= 1'b1;
               end
            end
            STREAM: begin
               if (take && at_last) begin
                  state     <= FILL;
                  wr_idx    <= '0;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= FILL;
               in_ready  <= 1'b0;
               out_valid <= 1'b0;
               full      <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

   // NOTE: storage has no reset; every word is rewritten by a fill before
   // it can be streamed out.
   always_ff @(posedge CLK) begin
      if (accept && !RST) begin
         for (int k = 0; k < LANES; k++) begin
            if ({1'b0, wr_idx} + (IDX_W+1)'(k) < (IDX_W+1)'(DEPTH))
               mem[wr_idx + IDX_W'(k)] <= in_data[k*WORDLEN +: WORDLEN];
         end
      end
   end

   // NOTE: rd_idx is assigned on every path so no latch is inferred.
   always_comb begin
      rd_idx = '0;
      if (mode_q == PASS)
         rd_idx = IDX_W'(row) * IDX_W'(N) + IDX_W'(col);
      else
         rd_idx = IDX_W'(col) * IDX_W'(N) + IDX_W'(row);
   end

   assign out_data = out_valid ? mem[rd_idx] : '0;
   assign out_last = out_valid && at_last;

endmodule

// File: tb/tb_q_transpose_stream.sv
// Directed bench for q_transpose_stream at N=3, LANES=2: fill, transpose,
// pass-through, backpressure, early start, refill and mid-stream reset.
module tb_q_transpose_stream;
   import q_transpose_pkg::*;

   localparam int W  = 16;
   localparam int N  = 3;
   localparam int L  = 2;
   localparam int NE = N * N;

   logic           CLK = 1'b0;
   logic           RST = 1'b1;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [L*W-1:0] in_data = '0;
   logic           start = 1'b0;
   logic           mode = 1'b0;
   logic           out_valid;
   logic           out_ready = 1'b0;
   logic [W-1:0]   out_data;
   logic           out_last;
   logic           full;
   logic           busy;
   logic           err_start;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic         mode;
      logic [W-1:0] data;
      logic         last;
   } vec_t;

   vec_t         vecs[4*NE];
   logic [W-1:0] fill_a[10];
   logic [W-1:0] fill_b[10];
   logic [W-1:0] exp_tab[4*NE];

   always #5 CLK = ~CLK;

   q_transpose_stream #(
      .WORDLEN        (W),
      .FRACTION_WIDTH (12),
      .N              (N),
      .LANES          (L)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .start     (start),
      .mode      (mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .full      (full),
      .busy      (busy),
      .err_start (err_start)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_in_ready();
      int n = 0;
      while (!in_ready && n < 20) begin
         tick();
         n++;
      end
      check("in_ready_wait", in_ready, 1);
   endtask

   // Five beats of matrix mat; optionally pulse start before beat early_at.
   task automatic fill(input int mat, input int early_at);
      for (int b = 0; b < 5; b++) begin
         if (b == early_at) begin
            start = 1'b1;
            mode  = 1'b1;
            tick();
            start = 1'b0;
            check("err_start_early", err_start, 1);
            check("no_valid_early", out_valid, 0);
            check("in_ready_early", in_ready, 1);
         end
         wait_in_ready();
         in_valid = 1'b1;
         in_data  = (mat == 0) ? {fill_a[2*b+1], fill_a[2*b]} : {fill_b[2*b+1], fill_b[2*b]};
         tick();
         in_valid = 1'b0;
      end
      check("full_after_fill", full, 1);
      check("in_ready_when_full", in_ready, 0);
   endtask

   task automatic start_stream(input logic m);
      start = 1'b1;
      mode  = m;
      tick();
      start = 1'b0;
      check("valid_after_start", out_valid, 1);
      check("busy_after_start", busy, 1);
      check("full_clear_stream", full, 0);
   endtask

   // Drain one matrix against vector group grp; hold out_ready low for
   // stall_len cycles once stall_after elements have been accepted.
   task automatic stream(input int grp, input int stall_after, input int stall_len);
      int k    = 0;
      int left = stall_len;
      int cyc  = 0;
      while (k < NE && cyc < 60) begin
         check("ready_valid_exclusive", in_ready & out_valid, 0);
         if (k == stall_after && left > 0) begin
            out_ready = 1'b0;
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, vecs[grp*NE+k].data);
            check("hold_last", out_last, vecs[grp*NE+k].last);
            left--;
         end else begin
            out_ready = 1'b1;
            if (out_valid) begin
               check("out_data", out_data, vecs[grp*NE+k].data);
               check("out_last", out_last, vecs[grp*NE+k].last);
               k++;
            end
         end
         tick();
         cyc++;
      end
      out_ready = 1'b0;
      check("element_count", k, NE);
      check("in_ready_after_last", in_ready, 1);
      check("valid_after_last", out_valid, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      fill_a  = '{16'h04cd, 16'h0333, 16'h0666, 16'h0B33, 16'h0400,
                  16'h0a66, 16'h1000, 16'h0000, 16'h0800, 16'hFFFF};
      fill_b  = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005,
                  16'h0006, 16'h0007, 16'h0008, 16'h0009, 16'hAAAA};
      exp_tab = '{16'h04cd, 16'h0B33, 16'h1000, 16'h0333, 16'h0400, 16'h0000, 16'h0666, 16'h0a66, 16'h0800,
                  16'h04cd, 16'h0333, 16'h0666, 16'h0B33, 16'h0400, 16'h0a66, 16'h1000, 16'h0000, 16'h0800,
                  16'h0001, 16'h0004, 16'h0007, 16'h0002, 16'h0005, 16'h0008, 16'h0003, 16'h0006, 16'h0009,
                  16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0007, 16'h0008, 16'h0009};
      for (int i = 0; i < 4*NE; i++) begin
         vecs[i].mode = ((i / NE) % 2 == 1) ? PASS : TRANSPOSE;
         vecs[i].data = exp_tab[i];
         vecs[i].last = (i % NE == NE - 1);
      end

      // Reset state
      repeat (2) @(posedge CLK);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_full", full, 0);
      check("rst_busy", busy, 0);
      check("rst_out_last", out_last, 0);
      check("rst_out_data", out_data, 0);
      check("rst_err_start", err_start, 0);
      RST = 1'b0;
      tick();
      check("in_ready_after_rst", in_ready, 1);

      // Fill, stall with in_valid while FULL, then transpose
      fill(0, -1);
      in_valid = 1'b1;
      in_data  = 32'hDEAD_BEEF;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_in_ready", in_ready, 0);
         check("stall_full", full, 1);
      end
      in_valid = 1'b0;
      start_stream(vecs[0].mode);
      stream(0, -1, 0);

      // Early start during fill, then pass-through
      fill(0, 1);
      start_stream(vecs[NE].mode);
      stream(1, -1, 0);

      // Transpose with backpressure after the second handshake
      fill(0, -1);
      start_stream(vecs[0].mode);
      stream(0, 2, 3);

      // Refill with a new matrix
      fill(1, -1);
      start_stream(vecs[2*NE].mode);
      stream(2, -1, 0);

      // Reset after the 4th output element
      fill(1, -1);
      check("err_start_sticky", err_start, 1);
      start_stream(vecs[3*NE].mode);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("pre_rst_data", out_data, vecs[3*NE+i].data);
         tick();
      end
      RST = 1'b1;
      tick();
      check("midrst_out_valid", out_valid, 0);
      check("midrst_full", full, 0);
      check("midrst_err_start", err_start, 0);
      check("midrst_busy", busy, 0);
      check("midrst_in_ready", in_ready, 0);
      check("midrst_out_data", out_data, 0);
      RST       = 1'b0;
      out_ready = 1'b0;
      tick();
      check("in_ready_after_midrst", in_ready, 1);
      fill(1, -1);
      start_stream(vecs[3*NE].mode);
      stream(3, -1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
